ps2_scancode_rx: RTL and testbench
==================================

// Module: ps2_scancode_rx
// PURPOSE
//  PS/2 keyboard device-to-host receiver: samples the keyboard's ps2_clk/ps2_data lines, deframes
//  11-bit frames, folds E0 (extended) and F0 (break) prefixes into flags, and emits one strobed
//  scancode event per key action. Producer side of the keyboardCode/ps2_ready pair that the
//  movement controller consumes (arrow keys arrive as E0 6B/74/75/72).
// PARAMETERS
//  FILTER_LEN   8        consecutive equal synced samples before the filtered ps2_clk level changes
//  TIMEOUT_CYC  100000   clk cycles without a ps2_clk falling edge mid-frame before abort (20-bit counter)
// PORTS
//  clk           in   1  system clock; the only clock in the block
//  rst           in   1  reset; asynchronous, active-low
//  ps2_clk       in   1  raw keyboard clock line; asynchronous to clk
//  ps2_data      in   1  raw keyboard data line; asynchronous to clk
//  keyboardCode  out  8  last completed scancode, prefixes stripped; held until the next event
//  ps2_ready     out  1  one-cycle strobe: keyboardCode/ps2_ext/ps2_break valid this cycle
//  ps2_ext       out  1  event was preceded by E0
//  ps2_break     out  1  event was preceded by F0 (key release)
//  frame_err     out  1  one-cycle strobe: frame discarded (framing, parity, or timeout)
// BEHAVIOUR
//  - Reset (rst=0, any time, incl. mid-frame): all outputs 0; filtered clk=1; FSM IDLE; bit count 0;
//    ext/brk pending flags cleared; timeout counter 0.
//  - Input path: 2-FF synchronizer on both lines; filtered ps2_clk per FILTER_LEN; falling edge of
//    filtered clk = one-cycle "fe" pulse; data sampled from its synchronized value in the fe cycle.
//  - Frame FSM: IDLE -> SHIFT on fe with data=0 (start bit); fe with data=1 in IDLE ignored.
//    SHIFT: bits 1..8 data LSB-first, bit 9 odd parity, bit 10 stop; on fe of bit 10 -> CHECK
//    (one cycle) -> IDLE. Frame accepted iff stop=1 (and parity odd, see CONFIGURATION).
//  - Prefix handling on accepted byte: E0 -> set ext pending; F0 -> set brk pending; no strobe
//    for either. Any other byte -> keyboardCode<=byte, ps2_ext<=ext pending, ps2_break<=brk
//    pending, ps2_ready=1 for exactly one cycle; pending flags cleared same cycle.
//  - Latency: ps2_ready/frame_err asserted in the cycle after the stop-bit fe cycle.
//  - Rejected frame: frame_err=1 one cycle; no ps2_ready; keyboardCode unchanged; pending flags cleared.
//  - Timeout: counter cleared on every fe and in IDLE; in SHIFT reaching TIMEOUT_CYC -> IDLE,
//    frame_err strobe, pending flags cleared. Never wraps (saturating compare).
//  - ps2_ready and frame_err never high in the same cycle. ps2_ext/ps2_break hold with keyboardCode.
//  - Block never drives ps2_clk/ps2_data (receive only).
// CONFIGURATION
//  PS2_PARITY_CHECK_EN defined: frame with even parity over data+parity bit is rejected (frame_err).
//  Not defined: parity bit shifted in and ignored; only stop bit=0 or timeout reject a frame.
// STRUCTURE
//  Package ps2_pkg: PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, arrow codes
//   (PS2_LEFT=8'h6B, PS2_RIGHT=8'h74, PS2_UP=8'h75, PS2_DOWN=8'h72), FSM state encoding
//   (IDLE/SHIFT/CHECK), frame length constant 11.
//  Sub-module ps2_line_filter: synchronizers + FILTER_LEN debounce + falling-edge pulse; outputs
//   fe and synced data. Top holds FSM, shift register, prefix flags, timeout counter.
// TESTING
//  1. Frame 0x1C, parity 0, stop 1 -> one-cycle ps2_ready, keyboardCode=8'h1C, ext=0, break=0.
//  2. Frames E0,6B -> no strobe after E0; single strobe code=8'h6B, ext=1, break=0.
//  3. Frames E0,F0,75 then 1C -> strobe 75 ext=1 break=1; then strobe 1C ext=0 break=0.
//  4. Frame 0x74 with parity bit 0 (wrong) -> macro on: frame_err, no ready, code unchanged;
//     macro off: ready, code=8'h74.
//  5. Frame 0x72 with stop bit 0 -> frame_err one cycle, no ready; next valid 0x72 decodes.
//  6. Stop clocking after 5 bits, wait TIMEOUT_CYC+10 -> one frame_err; following 0x1C decodes;
//     repeat with rst pulsed low mid-frame -> outputs 0 immediately, next frame decodes.
//  Also: 3-cycle glitch on ps2_clk (< FILTER_LEN) in IDLE and SHIFT -> no fe, no state change.

Source files
------------

// File: rtl/ps2_scancode_rx_pkg.sv
// Shared constants for the PS/2 scancode receiver: prefix bytes, arrow codes, frame FSM encoding.
// Latency: none; this file holds declarations only.
// Backpressure: none; this file holds declarations only.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [7:0] PS2_LEFT  = 8'h6B;
    localparam logic [7:0] PS2_RIGHT = 8'h74;
    localparam logic [7:0] PS2_UP    = 8'h75;
    localparam logic [7:0] PS2_DOWN  = 8'h72;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_LEN = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } ps2_state_t;

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Scancode event bundle from the PS/2 receiver to the key consumer.
// Latency: none; wires only.
// Backpressure: none; the consumer must take each strobed event in its cycle.
interface ps2_scancode_rx_if;
    logic [7:0] keyboardCode;
    logic       ps2_ready;
    logic       ps2_ext;
    logic       ps2_break;
    logic       frame_err;

    modport master (output keyboardCode, ps2_ready, ps2_ext, ps2_break, frame_err);
    modport slave  (input  keyboardCode, ps2_ready, ps2_ext, ps2_break, frame_err);
endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizes raw ps2_clk/ps2_data, debounces the clock line and pulses fe on its filtered falling edge.
// Latency: fe appears 2 sync + FILTER_LEN filter + 1 register cycles after a clean raw falling edge.
// Backpressure: none; the lines are sampled every cycle.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fe,
    output logic data_s
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic [CW-1:0] cnt;

    assign data_s = dat_sync[1];

    // Two-stage synchronizers; the idle PS/2 bus is high, so reset to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // The filtered level changes only after FILTER_LEN consecutive opposite samples; fe marks a 1->0 change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_filt <= 1'b1;
            cnt      <= '0;
            fe       <= 1'b0;
        end else begin
            fe <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                cnt      <= '0;
                fe       <= ~clk_sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, folds E0/F0 prefixes into flags, strobes one event per key action.
// Latency: ps2_ready/frame_err rise the cycle after the stop-bit fe cycle; keyboardCode/ps2_ext/ps2_break then hold.
// Backpressure: none; events are strobes. Build option PS2_PARITY_CHECK_EN rejects frames with bad odd parity.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    ps2_scancode_rx_if.master   kb
);

    localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_LEN - 1);
    localparam logic [19:0] TMO_LIM  = 20'(TIMEOUT_CYC - 1);

    logic       fe;
    logic       data_s;
    ps2_state_t state;
    logic [3:0] bit_cnt;
    logic [8:0] shreg;
    logic [9:0] frame_next;
    logic       ext_pend;
    logic       brk_pend;
    logic [19:0] tmo_cnt;
    logic       frame_ok;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fe       (fe),
        .data_s   (data_s)
    );

    // Bits enter at the top, so after the stop bit: [7:0] data, [8] parity, [9] stop.
    assign frame_next = {data_s, shreg};

    // Acceptance of the frame completing this cycle (only meaningful on the stop-bit fe).
    always_comb begin
        frame_ok = frame_next[9];
`ifdef PS2_PARITY_CHECK_EN
        frame_ok = frame_next[9] & (^frame_next[8:0]);
`endif
    end

    // Frame FSM with prefix folding, timeout and registered event outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            shreg           <= '0;
            ext_pend        <= 1'b0;
            brk_pend        <= 1'b0;
            tmo_cnt         <= '0;
            kb.keyboardCode <= '0;
            kb.ps2_ready    <= 1'b0;
            kb.ps2_ext      <= 1'b0;
            kb.ps2_break    <= 1'b0;
            kb.frame_err    <= 1'b0;
        end else begin
            kb.ps2_ready <= 1'b0;
            kb.frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    bit_cnt <= '0;
                    if (fe && !data_s) begin
                        state   <= SHIFT;
                        bit_cnt <= 4'd1;
                    end
                end
                SHIFT: begin
                    if (fe) begin
                        tmo_cnt <= '0;
                        shreg   <= frame_next[9:1];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= CHECK;
                            if (!frame_ok) begin
                                kb.frame_err <= 1'b1;
                                ext_pend     <= 1'b0;
                                brk_pend     <= 1'b0;
                            end else if (frame_next[7:0] == PS2_PREFIX_EXT) begin
                                ext_pend <= 1'b1;
                            end else if (frame_next[7:0] == PS2_PREFIX_BRK) begin
                                brk_pend <= 1'b1;
                            end else begin
                                kb.keyboardCode <= frame_next[7:0];
                                kb.ps2_ext      <= ext_pend;
                                kb.ps2_break    <= brk_pend;
                                kb.ps2_ready    <= 1'b1;
                                ext_pend        <= 1'b0;
                                brk_pend        <= 1'b0;
                            end
                        end
                    end else if (tmo_cnt >= TMO_LIM) begin
                        // Keyboard stopped clocking mid-frame: drop it.
                        state        <= IDLE;
                        tmo_cnt      <= '0;
                        kb.frame_err <= 1'b1;
                        ext_pend     <= 1'b0;
                        brk_pend     <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 20'd1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed frames into ps2_scancode_rx; expected events queued at issue, checked by an independent monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_scancode_rx;

    localparam int HALF = 20;
    localparam int TMO  = 2000;

    typedef struct {
        bit         err;
        logic [7:0] code;
        bit         ext;
        bit         brk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    int   n_total = 0;
    int   n_bad = 0;
    exp_t q[$];

    ps2_scancode_rx_if dut_if ();

    ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kb       (dut_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input bit par_ok, input bit stop);
        logic p;
        p = par_ok ? ~(^b) : (^b);
        return {stop, p, b, 1'b0};
    endfunction

    task automatic push(input bit err, input logic [7:0] code, input bit ext, input bit brk);
        exp_t e;
        e.err = err; e.code = code; e.ext = ext; e.brk = brk;
        q.push_back(e);
    endtask

    // Send the first n bits of a frame; optionally a 3-cycle low glitch during the high phase of bit glitch_at.
    task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_at);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF / 2) @(posedge clk);
            if (i == glitch_at) begin
                ps2_clk = 1'b0;
                repeat (3) @(posedge clk);
                ps2_clk = 1'b1;
            end
            repeat (HALF / 2) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * HALF) @(posedge clk);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && (dut_if.ps2_ready || dut_if.frame_err)) begin
            if (dut_if.ps2_ready && dut_if.frame_err) begin
                n_total++; n_bad++;
                $display("FAIL both_strobes: ready=1 err=1 expected at most one");
            end
            if (q.size() == 0) begin
                n_total++; n_bad++;
                $display("FAIL unexpected_event: ready=%0b err=%0b code=%h expected none",
                         dut_if.ps2_ready, dut_if.frame_err, dut_if.keyboardCode);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event_kind_err", {7'd0, dut_if.frame_err}, {7'd0, e.err});
                chk("code", dut_if.keyboardCode, e.code);
                if (!e.err) begin
                    chk("ext", {7'd0, dut_if.ps2_ext}, {7'd0, e.ext});
                    chk("brk", {7'd0, dut_if.ps2_break}, {7'd0, e.brk});
                end
            end
        end
    end

    initial begin
        repeat (4) @(posedge clk);
        #1;
        chk("rst_code", dut_if.keyboardCode, 8'h00);
        chk("rst_ready", {7'd0, dut_if.ps2_ready}, 8'h00);
        chk("rst_err", {7'd0, dut_if.frame_err}, 8'h00);
        rst = 1'b1;
        repeat (10) @(posedge clk);

        // 1: plain make code
        push(0, 8'h1C, 0, 0);
        send_bits(mk(8'h1C, 1, 1), 11, -1);

        // 2: extended arrow
        push(0, 8'h6B, 1, 0);
        send_bits(mk(8'hE0, 1, 1), 11, -1);
        send_bits(mk(8'h6B, 1, 1), 11, -1);

        // 3: extended break, then plain make clears flags
        push(0, 8'h75, 1, 1);
        send_bits(mk(8'hE0, 1, 1), 11, -1);
        send_bits(mk(8'hF0, 1, 1), 11, -1);
        send_bits(mk(8'h75, 1, 1), 11, -1);
        push(0, 8'h1C, 0, 0);
        send_bits(mk(8'h1C, 1, 1), 11, -1);

        // 4: bad parity
`ifdef PS2_PARITY_CHECK_EN
        push(1, 8'h1C, 0, 0);
        send_bits(mk(8'h74, 0, 1), 11, -1);
        // 5: bad stop bit, then a good frame
        push(1, 8'h1C, 0, 0);
`else
        push(0, 8'h74, 0, 0);
        send_bits(mk(8'h74, 0, 1), 11, -1);
        push(1, 8'h74, 0, 0);
`endif
        send_bits(mk(8'h72, 1, 0), 11, -1);
        push(0, 8'h72, 0, 0);
        send_bits(mk(8'h72, 1, 1), 11, -1);

        // 6: timeout after 5 bits, with a pending E0 that must be dropped
        send_bits(mk(8'hE0, 1, 1), 11, -1);
        push(1, 8'h72, 0, 0);
        send_bits(mk(8'h75, 1, 1), 5, -1);
        repeat (TMO + 10) @(posedge clk);
        push(0, 8'h1C, 0, 0);
        send_bits(mk(8'h1C, 1, 1), 11, -1);

        // Reset mid-frame
        send_bits(mk(8'h75, 1, 1), 5, -1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_code", dut_if.keyboardCode, 8'h00);
        chk("midrst_ready", {7'd0, dut_if.ps2_ready}, 8'h00);
        chk("midrst_ext", {7'd0, dut_if.ps2_ext}, 8'h00);
        chk("midrst_err", {7'd0, dut_if.frame_err}, 8'h00);
        repeat (5) @(posedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        push(0, 8'h72, 0, 0);
        send_bits(mk(8'h72, 1, 1), 11, -1);

        // Glitch in IDLE with data low would look like a start bit if not filtered
        ps2_data = 1'b0;
        repeat (5) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(posedge clk);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(posedge clk);
        push(0, 8'h74, 0, 0);
        send_bits(mk(8'h74, 1, 1), 11, -1);

        // Glitch in SHIFT must not add a bit
        push(0, 8'h6B, 0, 0);
        send_bits(mk(8'h6B, 1, 1), 11, 3);

        repeat (50) @(posedge clk);
        chk("queue_drained", 8'(q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
